// File: rtl/sdio_host_data_phy_if.sv
// sdio_host_data_phy_if: transaction, block-data and DAT[3:0] pad signals of the SDIO data PHY.
interface sdio_host_data_phy_if;
   logic        i_activate;
   logic        i_write_flag;
   logic [12:0] i_data_count;
   logic        o_finished;
   logic        i_data_rd_rdy;
   logic        o_data_rd_stb;
   logic [7:0]  i_data_rd_data;
   logic        o_data_wr_stb;
   logic [7:0]  o_data_wr_data;
   logic        o_data_crc_good;
   logic [2:0]  o_crc_status;
   logic        o_timeout;
   logic        o_sdio_data_dir;
   logic [3:0]  o_sdio_data_out;
   logic [3:0]  i_sdio_data_in;
   modport slave (
      input  i_activate, i_write_flag, i_data_count, i_data_rd_rdy, i_data_rd_data, i_sdio_data_in,
      output o_finished, o_data_rd_stb, o_data_wr_stb, o_data_wr_data, o_data_crc_good, o_crc_status,
             o_timeout, o_sdio_data_dir, o_sdio_data_out
   );
   modport master (
      output i_activate, i_write_flag, i_data_count, i_data_rd_rdy, i_data_rd_data, i_sdio_data_in,
      input  o_finished, o_data_rd_stb, o_data_wr_stb, o_data_wr_data, o_data_crc_good, o_crc_status,
             o_timeout, o_sdio_data_dir, o_sdio_data_out
   );
endinterface

// File: rtl/sdio_host_data_phy.sv
// sdio_host_data_phy: 4-bit SD/SDIO host data-line engine, one block per transaction with per-line CRC16.
// Every output is a register loaded with the value belonging to the state being entered.
module sdio_host_data_phy #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
   input logic                 clk,
   input logic                 rst,
   sdio_host_data_phy_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, WR_WAIT, WR_START, WR_DATA, WR_CRC, WR_END, WR_NCRC, WR_STATUS, WR_BUSY,
      RD_WAIT, RD_DATA, RD_CRC, RD_END, FINISHED
   } state_t;

   state_t           r_state, w_state;
   logic [13:0]      r_cnt, w_cnt;
   logic [15:0]      r_tmo, w_tmo;
   logic [7:0]       r_byte, w_byte;
   logic [3:0][15:0] r_crc, w_crc;
   logic             r_err, w_err;
   logic             r_fin;
   logic             r_dir, w_dir;
   logic [3:0]       r_dout, w_dout;
   logic             r_rd_stb, w_rd_stb;
   logic             r_wr_stb, w_wr_stb;
   logic [7:0]       r_wr_data, w_wr_data;
   logic             r_good, w_good;
   logic             r_tmo_flag, w_tmo_flag;
   logic [2:0]       r_status, w_status;
   logic [13:0]      w_len2m1;
   logic             w_expired;
   logic [3:0]       w_dat;

   function automatic logic [3:0][15:0] crc_nib(input logic [3:0][15:0] c, input logic [3:0] d);
      logic [3:0][15:0] s;
      for (int n = 0; n < 4; n++) s[n] = {c[n][14:0], 1'b0} ^ ({16{d[n] ^ c[n][15]}} & 16'h1021);
      return s;
   endfunction

   function automatic logic [3:0] crc_msb(input logic [3:0][15:0] c);
      logic [3:0] m;
      for (int n = 0; n < 4; n++) m[n] = c[n][15];
      return m;
   endfunction

   function automatic logic [3:0][15:0] crc_shl(input logic [3:0][15:0] c);
      logic [3:0][15:0] s;
      for (int n = 0; n < 4; n++) s[n] = {c[n][14:0], 1'b0};
      return s;
   endfunction

   assign w_dat     = bus.i_sdio_data_in;
   assign w_len2m1  = {bus.i_data_count, 1'b0} - 14'd1;
   assign w_expired = ({1'b0, r_tmo} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_byte     = r_byte;
      w_crc      = r_crc;
      w_err      = r_err;
      w_dir      = r_dir;
      w_dout     = r_dout;
      w_rd_stb   = 1'b0;
      w_wr_stb   = 1'b0;
      w_wr_data  = r_wr_data;
      w_good     = r_good;
      w_tmo_flag = r_tmo_flag;
      w_status   = r_status;
      case (r_state)
         IDLE: begin
            w_dir  = 1'b0;
            w_dout = 4'hF;
            if (bus.i_activate) begin
               w_good     = 1'b0;
               w_tmo_flag = 1'b0;
               w_crc      = '0;
               w_err      = 1'b0;
               w_cnt      = '0;
               w_state    = (bus.i_data_count == '0) ? FINISHED : bus.i_write_flag ? WR_WAIT : RD_WAIT;
            end
         end
         WR_WAIT: if (bus.i_data_rd_rdy) begin
            w_state  = WR_START;
            w_dir    = 1'b1;
            w_dout   = 4'h0;
            w_rd_stb = 1'b1;
         end
         WR_START: begin
            w_state = WR_DATA;
            w_byte  = bus.i_data_rd_data;
            w_dout  = bus.i_data_rd_data[7:4];
            w_crc   = crc_nib(r_crc, bus.i_data_rd_data[7:4]);
         end
         // Even count: high nibble on the bus, low nibble next; odd count: fetch the next byte.
         WR_DATA: begin
            w_cnt = r_cnt + 14'd1;
            if (!r_cnt[0]) begin
               w_dout   = r_byte[3:0];
               w_crc    = crc_nib(r_crc, r_byte[3:0]);
               w_rd_stb = (r_cnt + 14'd1) != w_len2m1;
            end else if (r_cnt == w_len2m1) begin
               w_state = WR_CRC;
               w_cnt   = '0;
               w_dout  = crc_msb(r_crc);
               w_crc   = crc_shl(r_crc);
            end else begin
               w_byte = bus.i_data_rd_data;
               w_dout = bus.i_data_rd_data[7:4];
               w_crc  = crc_nib(r_crc, bus.i_data_rd_data[7:4]);
            end
         end
         WR_CRC: begin
            w_cnt = r_cnt + 14'd1;
            if (r_cnt == 14'd15) begin
               w_state = WR_END;
               w_dout  = 4'hF;
            end else begin
               w_dout = crc_msb(r_crc);
               w_crc  = crc_shl(r_crc);
            end
         end
         WR_END: begin
            w_state = WR_NCRC;
            w_dir   = 1'b0;
            w_cnt   = '0;
         end
         WR_NCRC: begin
            w_cnt = r_cnt + 14'd1;
            if (r_cnt == 14'd1) begin
               w_state = WR_STATUS;
               w_cnt   = '0;
            end
         end
         WR_STATUS: begin
            if (r_cnt == '0) begin
               if (!w_dat[0]) w_cnt = 14'd1;
               else if (w_expired) begin
                  w_state    = FINISHED;
                  w_tmo_flag = 1'b1;
                  w_good     = 1'b0;
               end
            end else if (r_cnt < 14'd4) begin
               w_status = {r_status[1:0], w_dat[0]};
               w_cnt    = r_cnt + 14'd1;
            end else begin
               w_good  = (r_status == 3'b010) && w_dat[0];
               w_state = WR_BUSY;
               w_cnt   = '0;
            end
         end
         WR_BUSY: begin
            if (w_dat[0]) w_state = FINISHED;
            else if (w_expired) begin
               w_state    = FINISHED;
               w_tmo_flag = 1'b1;
               w_good     = 1'b0;
            end
         end
         RD_WAIT: begin
            if (w_dat == 4'h0) begin
               w_state = RD_DATA;
               w_cnt   = '0;
            end else if (w_expired) begin
               w_state    = FINISHED;
               w_tmo_flag = 1'b1;
            end
         end
         RD_DATA: begin
            w_cnt = r_cnt + 14'd1;
            w_crc = crc_nib(r_crc, w_dat);
            if (!r_cnt[0]) w_byte = {w_dat, r_byte[3:0]};
            else begin
               w_wr_stb  = 1'b1;
               w_wr_data = {r_byte[7:4], w_dat};
               if (r_cnt == w_len2m1) begin
                  w_state = RD_CRC;
                  w_cnt   = '0;
               end
            end
         end
         // Received CRC bits are checked against the computed CRC as they arrive.
         RD_CRC: begin
            w_cnt = r_cnt + 14'd1;
            w_err = r_err | (w_dat != crc_msb(r_crc));
            w_crc = crc_shl(r_crc);
            if (r_cnt == 14'd15) w_state = RD_END;
         end
         RD_END: begin
            w_state = FINISHED;
            w_good  = !r_err && (w_dat == 4'hF);
         end
         FINISHED: begin
            w_dir  = 1'b0;
            w_dout = 4'hF;
            if (!bus.i_activate) w_state = IDLE;
         end
         default: w_state = IDLE;
      endcase
      if (!bus.i_activate && r_state != IDLE && r_state != FINISHED) begin
         w_state  = IDLE;
         w_dir    = 1'b0;
         w_dout   = 4'hF;
         w_rd_stb = 1'b0;
         w_wr_stb = 1'b0;
      end
      w_tmo = (w_state != r_state) ? '0 : (&r_tmo) ? r_tmo : r_tmo + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_tmo      <= '0;
         r_byte     <= '0;
         r_crc      <= '0;
         r_err      <= 1'b0;
         r_fin      <= 1'b0;
         r_dir      <= 1'b0;
         r_dout     <= 4'hF;
         r_rd_stb   <= 1'b0;
         r_wr_stb   <= 1'b0;
         r_wr_data  <= '0;
         r_good     <= 1'b0;
         r_tmo_flag <= 1'b0;
         r_status   <= '0;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_tmo      <= w_tmo;
         r_byte     <= w_byte;
         r_crc      <= w_crc;
         r_err      <= w_err;
         r_fin      <= w_state == FINISHED;
         r_dir      <= w_dir;
         r_dout     <= w_dout;
         r_rd_stb   <= w_rd_stb;
         r_wr_stb   <= w_wr_stb;
         r_wr_data  <= w_wr_data;
         r_good     <= w_good;
         r_tmo_flag <= w_tmo_flag;
         r_status   <= w_status;
      end
   end

   assign bus.o_finished      = r_fin;
   assign bus.o_data_rd_stb   = r_rd_stb;
   assign bus.o_data_wr_stb   = r_wr_stb;
   assign bus.o_data_wr_data  = r_wr_data;
   assign bus.o_data_crc_good = r_good;
   assign bus.o_crc_status    = r_status;
   assign bus.o_timeout       = r_tmo_flag;
   assign bus.o_sdio_data_dir = r_dir;
   assign bus.o_sdio_data_out = r_dout;
endmodule
